// File: rtl/pattern_detect_pkg.sv
// Shared types, default sizes and helpers for the programmable pattern detector.
package pattern_detect_pkg;

    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Map a requested length onto the legal range 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/pattern_match_window.sv
// Serial history window with saturating fill count and masked pattern compare.
module pattern_match_window
    import pattern_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit_c
);

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] history_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;

    // Candidate next window and its compare result, as if x were shifted in now.
    always_comb begin
        history_shift = {history[MAX_LEN-2:0], x};
        fill_inc      = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        mask          = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit_c = (fill_inc >= len) && (((history_shift ^ pattern) & mask) == '0);
    end

    // History and fill registers; clear takes priority over shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= history_shift;
            fill    <= fill_inc;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Programmable serial sequence detector: config handshake, arm/run FSM, match counting.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   count_inc;
    logic               accept;
    logic               clear;
    logic               shift;
    logic               hit;
    logic               match_next;
    logic               done_next;

    pattern_match_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .shift   (shift),
        .x       (x),
        .pattern (pattern_q),
        .len     (len_q),
        .hit_c   (hit)
    );

    // Next-state, window control and next output values.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clear      = 1'b0;
        shift      = 1'b0;
        match_next = 1'b0;
        done_next  = done;
        count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
        count_next = match_count;
        unique case (state)
            IDLE, DONE: begin
                if (cfg_valid) begin
                    accept     = 1'b1;
                    clear      = 1'b1;
                    count_next = '0;
                    done_next  = 1'b0;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end else if (x_valid) begin
                    shift = 1'b1;
                    if (hit) begin
                        match_next = 1'b1;
                        count_next = count_inc;
                        if ((limit_q != '0) && (count_inc == limit_q)) begin
                            done_next  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            match       <= 1'b0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            cfg_ready   <= (state_next == IDLE) || (state_next == DONE);
            match       <= match_next;
            match_count <= count_next;
            busy        <= (state_next == RUN);
            done        <= done_next;
        end
    end

    // Configuration latch on handshake, with length clamped into range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            limit_q   <= '0;
        end else if (accept) begin
            pattern_q <= cfg_pattern;
            len_q     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            limit_q   <= cfg_limit;
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed self-checking bench for pattern_detect_ctrl.
module tb_pattern_detect_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_limit;
    logic               start;
    logic               abort;
    logic               x_valid;
    logic               x;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    pattern_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_limit   = lim;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Send n bits MSB first, checking match after each against exp (same bit order).
    task automatic send_bits(input string tag, input logic [15:0] bits, input int n,
                             input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            x_valid = 1'b1;
            x       = bits[i];
            tick();
            x_valid = 1'b0;
            check(tag, 32'(match), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [7:0] a5;
        int         gap;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_limit   = '0;
        start       = 1'b0;
        abort       = 1'b0;
        x_valid     = 1'b0;
        x           = 1'b0;
        #12;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_match", 32'(match), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Overlapping detection, unlimited
        do_cfg(8'b1011, 4'd4, 8'd0);
        check("ovl_armed_ready", 32'(cfg_ready), 32'd0);
        check("ovl_armed_busy", 32'(busy), 32'd0);
        do_start();
        check("ovl_busy", 32'(busy), 32'd1);
        send_bits("ovl_match", 16'b1011011, 7, 16'b0001001);
        tick();
        check("ovl_pulse_end", 32'(match), 32'd0);
        check("ovl_count", 32'(match_count), 32'd2);
        check("ovl_busy_after", 32'(busy), 32'd1);
        check("ovl_done", 32'(done), 32'd0);
        do_abort();
        check("ovl_abort_ready", 32'(cfg_ready), 32'd1);
        check("ovl_abort_count", 32'(match_count), 32'd2);

        // Limit stop at 2 matches
        do_cfg(8'b1011, 4'd4, 8'd2);
        check("lim_count_clr", 32'(match_count), 32'd0);
        do_start();
        send_bits("lim_a", 16'b1011, 4, 16'b0001);
        check("lim_done_early", 32'(done), 32'd0);
        send_bits("lim_b", 16'b1011, 4, 16'b0001);
        check("lim_done", 32'(done), 32'd1);
        send_bits("lim_c", 16'b1011, 4, 16'b0000);
        check("lim_count", 32'(match_count), 32'd2);
        check("lim_ready", 32'(cfg_ready), 32'd1);
        check("lim_busy", 32'(busy), 32'd0);
        check("lim_done_hold", 32'(done), 32'd1);

        // x_valid gaps, full-length pattern
        do_cfg(8'hA5, 4'd8, 8'd0);
        check("gap_done_clr", 32'(done), 32'd0);
        do_start();
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            x_valid = 1'b1;
            x       = a5[i];
            tick();
            x_valid = 1'b0;
            check("gap_match", 32'(match), (i == 0) ? 32'd1 : 32'd0);
            gap = (i == 0) ? 1 : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                x = 1'($urandom_range(0, 1));
                tick();
                check("gap_idle", 32'(match), 32'd0);
            end
        end
        check("gap_count", 32'(match_count), 32'd1);
        do_abort();

        // Length clamp: 0 -> 1
        do_cfg(8'h01, 4'd0, 8'd0);
        do_start();
        send_bits("clamp0", 16'b1101, 4, 16'b1101);
        check("clamp0_count", 32'(match_count), 32'd3);
        do_abort();

        // Length clamp: 15 -> 8
        do_cfg(8'hFF, 4'd15, 8'd0);
        do_start();
        send_bits("clamp15", 16'hFF, 8, 16'h01);
        check("clamp15_count", 32'(match_count), 32'd1);
        do_abort();

        // Abort clears partial history
        do_cfg(8'b1011, 4'd4, 8'd0);
        do_start();
        send_bits("abt_partial", 16'b101, 3, 16'b000);
        do_abort();
        do_cfg(8'b1011, 4'd4, 8'd0);
        do_start();
        send_bits("abt_fresh", 16'b1, 1, 16'b0);
        check("abt_count0", 32'(match_count), 32'd0);
        send_bits("abt_hit", 16'b011, 3, 16'b001);
        check("abt_count1", 32'(match_count), 32'd1);
        send_bits("abt_pre", 16'b01, 2, 16'b00);
        // completing bit together with abort
        x_valid = 1'b1;
        x       = 1'b1;
        abort   = 1'b1;
        tick();
        x_valid = 1'b0;
        abort   = 1'b0;
        check("abt_win_match", 32'(match), 32'd0);
        check("abt_win_count", 32'(match_count), 32'd1);
        check("abt_win_busy", 32'(busy), 32'd0);
        check("abt_win_ready", 32'(cfg_ready), 32'd1);

        // Asynchronous reset mid-run
        do_cfg(8'b1011, 4'd4, 8'd0);
        do_start();
        send_bits("ar_run", 16'b1011011011, 10, 16'b0001001001);
        check("ar_count3", 32'(match_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_match", 32'(match), 32'd0);
        check("ar_count", 32'(match_count), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_ready", 32'(cfg_ready), 32'd1);
        #2;
        reset = 1'b0;
        tick();
        do_cfg(8'b1011, 4'd4, 8'd1);
        check("ar_cfg_accept", 32'(cfg_ready), 32'd0);
        do_start();
        send_bits("ar_post", 16'b1011, 4, 16'b0001);
        check("ar_post_done", 32'(done), 32'd1);
        check("ar_post_count", 32'(match_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
